// File: rtl/mac_pkg.sv
// mac_pkg: shared constants, state encoding and CRC-32 byte helper for the
// Ethernet MAC transmitter (and its receiver counterpart).
package mac_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [5:0]  MIN_PAYLOAD   = 6'd46;
   localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_PRE     = 4'd1,
      S_DST     = 4'd2,
      S_SRC     = 4'd3,
      S_TYPE    = 4'd4,
      S_PAYLOAD = 4'd5,
      S_PAD     = 4'd6,
      S_FCS     = 4'd7,
      S_IFG     = 4'd8
   } state_t;

   // Bit-reverse a 32-bit word (Ethernet CRC runs LSB first).
   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      r = 32'd0;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

   localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

   // One byte of reflected CRC-32, data consumed LSB first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'd0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/mac_tx_crc32_d8.sv
// crc32_d8: byte-wide CRC-32 register (IEEE 802.3, reflected).
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_init         : load CRC_INIT (has priority over i_en)
//   i_en           : fold i_data into the running CRC
//   i_data         : byte to fold in
//   o_crc          : raw running CRC register (no final XOR)
module crc32_d8
   import mac_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_init,
   input  logic        i_en,
   input  logic [7:0]  i_data,
   output logic [31:0] o_crc
);

   logic [31:0] crc_d;
   logic [31:0] crc_q;

   // Next CRC value: init, update or hold.
   always_comb begin
      crc_d = crc_q;
      if (i_init) begin
         crc_d = CRC_INIT;
      end else if (i_en) begin
         crc_d = crc32_byte(crc_q, i_data);
      end else begin
         crc_d = crc_q;
      end
   end

   // CRC register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         crc_q <= CRC_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign o_crc = crc_q;

endmodule

// File: rtl/mac_tx.sv
// mac_tx: Ethernet MAC transmitter. Wraps an upstream byte stream as
// preamble + SFD + dst + src + type + payload [+ pad] + FCS and drives GMII.
// Ports:
//   i_clk, i_rst_n                  : GMII TX clock, async active-low reset
//   i_target_mac/_valid             : runtime destination MAC load
//   i_source_mac/_valid             : runtime source MAC load
//   i_send_type                     : EtherType, sampled at frame start
//   i_send_data/_last/_valid        : payload stream from upper layer
//   o_send_ready                    : payload byte accepted on valid & ready
//   o_tx_underrun                   : 1-cycle pulse when payload valid drops early
//   o_GMII_data, o_GMII_valid       : GMII TXD / TX_EN
// Build option: define MAC_TX_PAD_EN to pad short payloads to 46 bytes.
module mac_tx
   import mac_pkg::*;
#(
   parameter logic [47:0] P_TARGET_MAC = 48'hFF_FF_FF_FF_FF_FF,
   parameter logic [47:0] P_SOURCE_MAC = 48'h00_0A_35_01_FE_C0,
   parameter int          P_IFG_CYCLES = 12
)(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [47:0] i_target_mac,
   input  logic        i_target_mac_valid,
   input  logic [47:0] i_source_mac,
   input  logic        i_source_mac_valid,
   input  logic [15:0] i_send_type,
   input  logic [7:0]  i_send_data,
   input  logic        i_send_last,
   input  logic        i_send_valid,
   output logic        o_send_ready,
   output logic        o_tx_underrun,
   output logic [7:0]  o_GMII_data,
   output logic        o_GMII_valid
);

   localparam logic [7:0] IFG_LAST = 8'(P_IFG_CYCLES - 1);

   state_t       state_d, state_q;
   logic [7:0]   cnt_d, cnt_q;
   logic [111:0] hdr_d, hdr_q;        // {dst, src, type} shifted out MSB byte first
   logic         stomp_d, stomp_q;
   logic [47:0]  dst_d, dst_q;
   logic [47:0]  src_d, src_q;
   logic [7:0]   gmii_data_d, gmii_data_q;
   logic         gmii_valid_d, gmii_valid_q;
   logic         ready_d, ready_q;
   logic         underrun_d, underrun_q;
`ifdef MAC_TX_PAD_EN
   logic [5:0]   pay_cnt_d, pay_cnt_q;
`endif

   logic         crc_init_s;
   logic         crc_en_s;
   logic [7:0]   crc_data_s;
   logic [31:0]  crc_s;
   logic [31:0]  fcs_s;

   crc32_d8 u_crc (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_init  (crc_init_s),
      .i_en    (crc_en_s),
      .i_data  (crc_data_s),
      .o_crc   (crc_s)
   );

   // A stomped frame sends the raw register, i.e. the complement of the good FCS.
   assign fcs_s = stomp_q ? crc_s : ~crc_s;

   // Runtime MAC registers; a frame in flight uses its own latched copy in hdr_q.
   always_comb begin
      dst_d = i_target_mac_valid ? i_target_mac : dst_q;
      src_d = i_source_mac_valid ? i_source_mac : src_q;
   end

   // Next-state and registered-output logic. Each state computes the byte
   // that appears on GMII one cycle later.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hdr_d        = hdr_q;
      stomp_d      = stomp_q;
      gmii_data_d  = 8'h00;
      gmii_valid_d = 1'b0;
      underrun_d   = 1'b0;
      crc_init_s   = 1'b0;
      crc_en_s     = 1'b0;
      crc_data_s   = 8'h00;
`ifdef MAC_TX_PAD_EN
      pay_cnt_d    = pay_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (i_send_valid) begin
               // First preamble byte goes out directly so it lands on GMII next cycle.
               state_d      = S_PRE;
               cnt_d        = 8'd1;
               hdr_d        = {dst_q, src_q, i_send_type};
               stomp_d      = 1'b0;
               gmii_data_d  = PREAMBLE_BYTE;
               gmii_valid_d = 1'b1;
`ifdef MAC_TX_PAD_EN
               pay_cnt_d    = 6'd0;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PRE: begin
            gmii_valid_d = 1'b1;
            if (cnt_q == 8'd7) begin
               gmii_data_d = SFD_BYTE;
               crc_init_s  = 1'b1;
               state_d     = S_DST;
               cnt_d       = 8'd0;
            end else begin
               gmii_data_d = PREAMBLE_BYTE;
               cnt_d       = cnt_q + 8'd1;
            end
         end
         S_DST, S_SRC, S_TYPE: begin
            gmii_valid_d = 1'b1;
            gmii_data_d  = hdr_q[111:104];
            crc_en_s     = 1'b1;
            crc_data_s   = hdr_q[111:104];
            hdr_d        = {hdr_q[103:0], 8'h00};
            if ((state_q == S_DST) && (cnt_q == 8'd5)) begin
               state_d = S_SRC;
               cnt_d   = 8'd0;
            end else if ((state_q == S_SRC) && (cnt_q == 8'd5)) begin
               state_d = S_TYPE;
               cnt_d   = 8'd0;
            end else if ((state_q == S_TYPE) && (cnt_q == 8'd1)) begin
               state_d = S_PAYLOAD;
               cnt_d   = 8'd0;
            end else begin
               cnt_d   = cnt_q + 8'd1;
            end
         end
         S_PAYLOAD: begin
            gmii_valid_d = 1'b1;
            if (i_send_valid) begin
               gmii_data_d = i_send_data;
               crc_en_s    = 1'b1;
               crc_data_s  = i_send_data;
`ifdef MAC_TX_PAD_EN
               pay_cnt_d   = (pay_cnt_q == MIN_PAYLOAD) ? pay_cnt_q : (pay_cnt_q + 6'd1);
`endif
               if (i_send_last) begin
                  cnt_d = 8'd0;
`ifdef MAC_TX_PAD_EN
                  if (pay_cnt_q < (MIN_PAYLOAD - 6'd1)) begin
                     state_d = S_PAD;
                  end else begin
                     state_d = S_FCS;
                  end
`else
                  state_d = S_FCS;
`endif
               end else begin
                  state_d = S_PAYLOAD;
               end
            end else begin
               // Underrun: no byte to send, so FCS byte 0 (stomped) fills this slot
               // to keep TX_EN continuous.
               underrun_d  = 1'b1;
               stomp_d     = 1'b1;
               gmii_data_d = crc_s[7:0];
               state_d     = S_FCS;
               cnt_d       = 8'd1;
            end
         end
`ifdef MAC_TX_PAD_EN
         S_PAD: begin
            gmii_valid_d = 1'b1;
            gmii_data_d  = 8'h00;
            crc_en_s     = 1'b1;
            crc_data_s   = 8'h00;
            pay_cnt_d    = pay_cnt_q + 6'd1;
            if (pay_cnt_q == (MIN_PAYLOAD - 6'd1)) begin
               state_d = S_FCS;
               cnt_d   = 8'd0;
            end else begin
               state_d = S_PAD;
            end
         end
`endif
         S_FCS: begin
            gmii_valid_d = 1'b1;
            case (cnt_q[1:0])
               2'd0:    gmii_data_d = fcs_s[7:0];
               2'd1:    gmii_data_d = fcs_s[15:8];
               2'd2:    gmii_data_d = fcs_s[23:16];
               2'd3:    gmii_data_d = fcs_s[31:24];
               default: gmii_data_d = 8'h00;
            endcase
            if (cnt_q == 8'd3) begin
               state_d = S_IFG;
               cnt_d   = 8'd0;
            end else begin
               cnt_d   = cnt_q + 8'd1;
            end
         end
         S_IFG: begin
            if (cnt_q == IFG_LAST) begin
               state_d = S_IDLE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d   = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
      ready_d = (state_d == S_PAYLOAD);
   end

   // State, datapath and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= 8'd0;
         hdr_q        <= 112'd0;
         stomp_q      <= 1'b0;
         dst_q        <= P_TARGET_MAC;
         src_q        <= P_SOURCE_MAC;
         gmii_data_q  <= 8'h00;
         gmii_valid_q <= 1'b0;
         ready_q      <= 1'b0;
         underrun_q   <= 1'b0;
`ifdef MAC_TX_PAD_EN
         pay_cnt_q    <= 6'd0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hdr_q        <= hdr_d;
         stomp_q      <= stomp_d;
         dst_q        <= dst_d;
         src_q        <= src_d;
         gmii_data_q  <= gmii_data_d;
         gmii_valid_q <= gmii_valid_d;
         ready_q      <= ready_d;
         underrun_q   <= underrun_d;
`ifdef MAC_TX_PAD_EN
         pay_cnt_q    <= pay_cnt_d;
`endif
      end
   end

   assign o_send_ready  = ready_q;
   assign o_tx_underrun = underrun_q;
   assign o_GMII_data   = gmii_data_q;
   assign o_GMII_valid  = gmii_valid_q;

endmodule
